sram_lambda_mp: RTL and testbench
=================================

Name: sram_lambda_mp

Overview:
- Parametrised successor of the LDPC lambda storage SRAM: one write port and one read port usable in the same cycle, with configurable width, depth and read latency.
- Adds a post-reset clear sweep, write-first bypass for same-address read/write, a read-valid strobe and an out-of-range error flag.
- Sits between the channel-LLR loader and the variable-node update datapath; holds one lambda word per variable node.

Parameters:
- DATA_W, 16, width of one lambda word.
- DEPTH, 400, number of words; legal addresses are 0..DEPTH-1.
- ADDR_W, 20, address port width; must satisfy 2**ADDR_W >= DEPTH.
- OUT_REG, 0, 0 gives 1-cycle read latency; 1 adds an output register for 2-cycle latency.
- CLR_VAL, 0, DATA_W-bit value written to every word by the clear sweep.

Ports:
- clk  in  1  single clock; all logic on posedge.
- rst  in  1  synchronous reset, active-high.
- i_wen  in  1  write enable.
- i_waddr  in  ADDR_W  write address.
- i_wdata  in  DATA_W  write data.
- i_ren  in  1  read enable; independent of i_wen.
- i_raddr  in  ADDR_W  read address.
- o_rdata  out  DATA_W  read data; holds its value between reads.
- o_rvalid  out  1  one-cycle strobe, aligned with o_rdata, per accepted read.
- o_busy  out  1  high while reset or the clear sweep is active.
- o_err  out  1  sticky flag for an out-of-range access.

Behaviour:
- Reset:
  - rst is sampled on posedge clk; rst=1 forces state CLEAR and clear counter = 0.
  - Outputs while rst=1: o_rdata=0, o_rvalid=0, o_busy=1, o_err=0.
  - All pipeline valid bits are cleared.
- States: CLEAR, RUN.
  - CLEAR: one word per cycle, mem[cnt] <= CLR_VAL, cnt increments.
  - When cnt == DEPTH-1 is written, go to RUN next cycle. The sweep takes exactly DEPTH cycles after rst deasserts.
  - o_busy=1 throughout CLEAR; o_busy=0 in the first RUN cycle.
  - In CLEAR, i_wen and i_ren are ignored: no memory write, no o_rvalid, no o_err update.
  - rst asserted mid-sweep restarts the sweep at address 0.
- Write (RUN): i_wen=1 and i_waddr<DEPTH gives mem[i_waddr] <= i_wdata at that posedge.
- Read (RUN): i_ren=1 is accepted.
  - OUT_REG=0: o_rdata and o_rvalid update at the next posedge.
  - OUT_REG=1: they update one posedge later.
  - Back-to-back reads sustain one result per cycle.
  - o_rvalid is high for exactly one cycle per accepted read.
- Simultaneous read and write to the same in-range address (write-first):
  - The read returns i_wdata of that cycle, not the old content.
  - Different addresses proceed independently.
- Out-of-range (address >= DEPTH):
  - Write: dropped; o_err <= 1.
  - Read: still produces o_rvalid with o_rdata = CLR_VAL; o_err <= 1.
  - o_err stays set until rst.
- No read accepted: o_rdata holds its last value and o_rvalid=0.
- Memory content is undefined only before the first sweep completes. After the sweep, every word equals CLR_VAL until written.

Decomposition:
- Package ldpc_mem_pkg holds:
  - default LAMBDA_W=16, LAMBDA_DEPTH=400, LAMBDA_ADDR_W=20;
  - state enum {CLEAR, RUN}, shared with the other LDPC memories (beta, syndrome).
- One sub-module, sram_lambda_core:
  - bare synchronous 1W1R array, no reset, inferable as block RAM;
  - the wrapper owns the FSM, the bypass compare/mux, the range checks, the output register and the flags.

Test Plan:
- Clear sweep: rst high 2 cycles, then low, DEPTH=400 → o_busy=1 for exactly 400 cycles after deassert. Reads of addresses 0, 199 and 399 then return 0x0000 with o_rvalid one cycle after i_ren.
- Basic write/read, OUT_REG=0: write 0xA5A5 @ 7, then read @ 7 → o_rdata=0xA5A5 with o_rvalid at cycle+1. Repeat with OUT_REG=1 → valid at cycle+2.
- Bypass: same cycle, i_wen @ 12 with 0x1234 and i_ren @ 12, old content 0 → o_rdata=0x1234. Read @ 12 next cycle → 0x1234.
- Streaming: 400 back-to-back writes (data=addr), then 400 back-to-back reads → 400 consecutive o_rvalid pulses, o_rdata=addr each.
- Out-of-range: write 0xFFFF @ 400, then read @ 400 → o_rdata=CLR_VAL, o_rvalid=1, o_err=1 and held. Address 399 is unmodified. rst clears o_err.
- Reset mid-sweep: assert rst at sweep cycle 150 after writing user data pre-reset → sweep restarts, o_busy=1 for 400 cycles after release. Accesses during the sweep are ignored (no o_rvalid). All words end at CLR_VAL.

Source files
------------

// File: rtl/ldpc_mem_pkg.sv
`default_nettype none
// ============================================================================
// ldpc_mem_pkg : shared defaults and state encodings for the LDPC memories
// Revision     : 1.0
// ============================================================================
package ldpc_mem_pkg;

   localparam int LAMBDA_W      = 16;
   localparam int LAMBDA_DEPTH  = 400;
   localparam int LAMBDA_ADDR_W = 20;

   typedef enum logic [0:0] {
      CLEAR = 1'b0,
      RUN   = 1'b1
   } mem_state_t;

   // Source of the word presented on the read port after an accepted read.
   typedef enum logic [1:0] {
      SEL_ZERO = 2'd0,
      SEL_MEM  = 2'd1,
      SEL_BYP  = 2'd2,
      SEL_CLR  = 2'd3
   } rd_sel_t;

   function automatic int addr_bits(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/sram_lambda_core.sv
`default_nettype none
// ============================================================================
// sram_lambda_core : bare synchronous 1W1R array, no reset (block-RAM style)
// Revision         : 1.0
// ============================================================================
module sram_lambda_core #(
   parameter int DATA_W = 16,
   parameter int DEPTH  = 400,
   parameter int AW     = 9
) (
   input  logic              clk,
   input  logic              we,
   input  logic [AW-1:0]     waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              re,
   input  logic [AW-1:0]     raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (re) begin
         rdata <= mem[raddr];
      end
   end

endmodule
`default_nettype wire

// File: rtl/sram_lambda_mp.sv
`default_nettype none
// ============================================================================
// sram_lambda_mp : LDPC lambda SRAM with clear sweep, write-first bypass,
//                  read-valid strobe and sticky out-of-range flag
// Revision       : 1.0
// ============================================================================
module sram_lambda_mp
   import ldpc_mem_pkg::*;
#(
   parameter int                DATA_W  = LAMBDA_W,
   parameter int                DEPTH   = LAMBDA_DEPTH,
   parameter int                ADDR_W  = LAMBDA_ADDR_W,
   parameter int                OUT_REG = 0,
   parameter logic [DATA_W-1:0] CLR_VAL = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_wen,
   input  logic [ADDR_W-1:0] i_waddr,
   input  logic [DATA_W-1:0] i_wdata,
   input  logic              i_ren,
   input  logic [ADDR_W-1:0] i_raddr,
   output logic [DATA_W-1:0] o_rdata,
   output logic              o_rvalid,
   output logic              o_busy,
   output logic              o_err
);

   localparam int                MEM_AW = addr_bits(DEPTH);
   localparam logic [ADDR_W:0]   LIMIT  = (ADDR_W+1)'(DEPTH);
   localparam logic [MEM_AW-1:0] LAST   = MEM_AW'(DEPTH-1);

   mem_state_t        state, state_nxt;
   logic [MEM_AW-1:0] cnt, cnt_nxt;

   logic              run;
   logic              wr_in_range, rd_in_range;
   logic              wr_ok, rd_acc, rd_ok, bypass;

   logic              mem_we;
   logic [MEM_AW-1:0] mem_waddr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   rd_sel_t           sel;
   logic [DATA_W-1:0] byp_data;
   logic              rv1;
   logic [DATA_W-1:0] rd1;
   logic              err;

   assign run         = (state == RUN);
   assign wr_in_range = ({1'b0, i_waddr} < LIMIT);
   assign rd_in_range = ({1'b0, i_raddr} < LIMIT);
   assign wr_ok       = run & i_wen & wr_in_range;
   assign rd_acc      = run & i_ren;
   assign rd_ok       = rd_acc & rd_in_range;
   assign bypass      = rd_ok & wr_ok & (i_waddr == i_raddr);

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= CLEAR;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // The sweep borrows the write port; user writes are only routed in RUN.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      mem_we    = wr_ok;
      mem_waddr = i_waddr[MEM_AW-1:0];
      mem_wdata = i_wdata;
      case (state)
         CLEAR: begin
            mem_we    = 1'b1;
            mem_waddr = cnt;
            mem_wdata = CLR_VAL;
            cnt_nxt   = cnt + MEM_AW'(1);
            if (cnt == LAST) begin
               state_nxt = RUN;
               cnt_nxt   = '0;
            end
         end
         RUN:     state_nxt = RUN;
         default: state_nxt = CLEAR;
      endcase
   end

   sram_lambda_core #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .AW     (MEM_AW)
   ) u_core (
      .clk   (clk),
      .we    (mem_we),
      .waddr (mem_waddr),
      .wdata (mem_wdata),
      .re    (rd_ok & ~bypass),
      .raddr (i_raddr[MEM_AW-1:0]),
      .rdata (mem_rdata)
   );

   // The select only moves on an accepted read, so the output holds otherwise.
   always_ff @(posedge clk) begin
      if (rst) begin
         rv1      <= 1'b0;
         sel      <= SEL_ZERO;
         byp_data <= '0;
         err      <= 1'b0;
      end else begin
         rv1 <= rd_acc;
         if (rd_acc) begin
            if (!rd_in_range) begin
               sel <= SEL_CLR;
            end else if (bypass) begin
               sel <= SEL_BYP;
            end else begin
               sel <= SEL_MEM;
            end
         end
         if (bypass) begin
            byp_data <= i_wdata;
         end
         if (run && ((i_wen && !wr_in_range) || (i_ren && !rd_in_range))) begin
            err <= 1'b1;
         end
      end
   end

   always_comb begin
      rd1 = '0;
      case (sel)
         SEL_MEM:  rd1 = mem_rdata;
         SEL_BYP:  rd1 = byp_data;
         SEL_CLR:  rd1 = CLR_VAL;
         default:  rd1 = '0;
      endcase
   end

   generate
      if (OUT_REG != 0) begin : g_out_reg
         logic [DATA_W-1:0] rdata_q;
         logic              rv2;
         always_ff @(posedge clk) begin
            if (rst) begin
               rdata_q <= '0;
               rv2     <= 1'b0;
            end else begin
               rv2 <= rv1;
               if (rv1) begin
                  rdata_q <= rd1;
               end
            end
         end
         assign o_rdata  = rdata_q;
         assign o_rvalid = rv2;
      end else begin : g_no_out_reg
         assign o_rdata  = rd1;
         assign o_rvalid = rv1;
      end
   endgenerate

   assign o_busy = rst | ~run;
   assign o_err  = err;

endmodule
`default_nettype wire

// File: tb/tb_sram_lambda_mp.sv
`default_nettype none
// ============================================================================
// tb_sram_lambda_mp : directed bench for sram_lambda_mp, OUT_REG=0 and 1 side by side
// Revision          : 1.0
// ============================================================================
module tb_sram_lambda_mp;

   logic        clk = 1'b0;
   logic        rst;
   logic        wen, ren;
   logic [19:0] waddr, raddr;
   logic [15:0] wdata;
   logic [15:0] rdata0, rdata1;
   logic        rvalid0, rvalid1, busy0, busy1, err0, err1;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   sram_lambda_mp #(.OUT_REG(0)) u_dut0 (
      .clk(clk), .rst(rst), .i_wen(wen), .i_waddr(waddr), .i_wdata(wdata),
      .i_ren(ren), .i_raddr(raddr), .o_rdata(rdata0), .o_rvalid(rvalid0),
      .o_busy(busy0), .o_err(err0)
   );

   sram_lambda_mp #(.OUT_REG(1)) u_dut1 (
      .clk(clk), .rst(rst), .i_wen(wen), .i_waddr(waddr), .i_wdata(wdata),
      .i_ren(ren), .i_raddr(raddr), .o_rdata(rdata1), .o_rvalid(rvalid1),
      .o_busy(busy1), .o_err(err1)
   );

   typedef struct {
      logic        wen;
      logic [19:0] waddr;
      logic [15:0] wdata;
      logic        ren;
      logic [19:0] raddr;
      logic        ev;
      logic [15:0] ed;
      logic        ee;
   } vec_t;

   vec_t vecs[14];

   function automatic vec_t mkv(input logic w, input int wa, input int wd,
                                input logic r, input int ra,
                                input logic ev, input int ed, input logic ee);
      vec_t v;
      v.wen = w;  v.waddr = 20'(wa); v.wdata = 16'(wd);
      v.ren = r;  v.raddr = 20'(ra);
      v.ev  = ev; v.ed    = 16'(ed); v.ee    = ee;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Counts busy cycles of both instances and any read strobe seen meanwhile.
   task automatic sweep(output int n0, output int n1, output int pv);
      n0 = 0; n1 = 0; pv = 0;
      for (int t = 0; t < 1000 && (busy0 || busy1); t++) begin
         if (busy0) n0++;
         if (busy1) n1++;
         if (rvalid0 || rvalid1) pv++;
         @(negedge clk);
      end
   endtask

   task automatic rd_check(input logic [19:0] a, input logic [15:0] e, input string nm);
      ren = 1'b1; raddr = a;
      @(negedge clk);
      ren = 1'b0;
      check({nm, " v0"}, 32'(rvalid0), 32'd1);
      check({nm, " d0"}, 32'(rdata0), 32'(e));
      check({nm, " v1 early"}, 32'(rvalid1), 32'd0);
      @(negedge clk);
      check({nm, " v0 strobe"}, 32'(rvalid0), 32'd0);
      check({nm, " v1"}, 32'(rvalid1), 32'd1);
      check({nm, " d1"}, 32'(rdata1), 32'(e));
   endtask

   initial begin
      int n0, n1, pv;
      int good0, good1, pulses0, pulses1;
      logic        pev;
      logic [15:0] ped;

      rst = 1'b1; wen = 1'b0; ren = 1'b0;
      waddr = '0; raddr = '0; wdata = '0;

      // Reset state
      repeat (2) @(negedge clk);
      check("rst busy0", 32'(busy0), 32'd1);
      check("rst busy1", 32'(busy1), 32'd1);
      check("rst rvalid0", 32'(rvalid0), 32'd0);
      check("rst rvalid1", 32'(rvalid1), 32'd0);
      check("rst rdata0", 32'(rdata0), 32'd0);
      check("rst rdata1", 32'(rdata1), 32'd0);
      check("rst err0", 32'(err0), 32'd0);
      check("rst err1", 32'(err1), 32'd0);

      // Clear sweep length
      rst = 1'b0;
      sweep(n0, n1, pv);
      check("sweep len0", 32'(n0), 32'd400);
      check("sweep len1", 32'(n1), 32'd400);

      // Directed vectors: one per cycle; dut1 trails dut0 by one cycle
      vecs[0]  = mkv(0, 0,   0,      1, 0,   1, 0,      0);
      vecs[1]  = mkv(0, 0,   0,      1, 199, 1, 0,      0);
      vecs[2]  = mkv(0, 0,   0,      1, 399, 1, 0,      0);
      vecs[3]  = mkv(1, 7,   'hA5A5, 0, 0,   0, 0,      0);
      vecs[4]  = mkv(0, 0,   0,      1, 7,   1, 'hA5A5, 0);
      vecs[5]  = mkv(1, 12,  'h1234, 1, 12,  1, 'h1234, 0);
      vecs[6]  = mkv(0, 0,   0,      1, 12,  1, 'h1234, 0);
      vecs[7]  = mkv(0, 0,   0,      0, 0,   0, 'h1234, 0);
      vecs[8]  = mkv(1, 5,   'h0BEE, 1, 6,   1, 0,      0);
      vecs[9]  = mkv(0, 0,   0,      1, 5,   1, 'h0BEE, 0);
      vecs[10] = mkv(1, 400, 'hFFFF, 0, 0,   0, 'h0BEE, 1);
      vecs[11] = mkv(0, 0,   0,      1, 400, 1, 0,      1);
      vecs[12] = mkv(0, 0,   0,      1, 399, 1, 0,      1);
      vecs[13] = mkv(0, 0,   0,      0, 0,   0, 0,      1);

      pev = 1'b0; ped = '0;
      for (int i = 0; i < 14; i++) begin
         wen = vecs[i].wen; waddr = vecs[i].waddr; wdata = vecs[i].wdata;
         ren = vecs[i].ren; raddr = vecs[i].raddr;
         @(negedge clk);
         check($sformatf("vec%0d v0", i), 32'(rvalid0), 32'(vecs[i].ev));
         check($sformatf("vec%0d d0", i), 32'(rdata0), 32'(vecs[i].ed));
         check($sformatf("vec%0d err0", i), 32'(err0), 32'(vecs[i].ee));
         check($sformatf("vec%0d v1", i), 32'(rvalid1), 32'(pev));
         check($sformatf("vec%0d d1", i), 32'(rdata1), 32'(ped));
         pev = vecs[i].ev; ped = vecs[i].ed;
      end
      wen = 1'b0; ren = 1'b0;
      @(negedge clk);
      check("vec13 v1", 32'(rvalid1), 32'(pev));
      check("vec13 d1", 32'(rdata1), 32'(ped));
      check("err1 held", 32'(err1), 32'd1);

      // Streaming: 400 writes then 400 back-to-back reads
      for (int k = 0; k < 400; k++) begin
         wen = 1'b1; waddr = 20'(k); wdata = 16'(k);
         @(negedge clk);
      end
      wen = 1'b0;
      good0 = 0; good1 = 0; pulses0 = 0; pulses1 = 0;
      for (int k = 0; k < 403; k++) begin
         ren = (k < 400); raddr = 20'(k);
         @(negedge clk);
         if (rvalid0) begin
            pulses0++;
            if (k < 400 && rdata0 == 16'(k)) good0++;
         end
         if (rvalid1) begin
            pulses1++;
            if (k >= 1 && k <= 400 && rdata1 == 16'(k - 1)) good1++;
         end
      end
      ren = 1'b0;
      check("stream pulses0", 32'(pulses0), 32'd400);
      check("stream good0", 32'(good0), 32'd400);
      check("stream pulses1", 32'(pulses1), 32'd400);
      check("stream good1", 32'(good1), 32'd400);
      check("err0 sticky", 32'(err0), 32'd1);

      // User data before a reset that is repeated mid-sweep
      wen = 1'b1; waddr = 20'd50; wdata = 16'hBEEF;
      @(negedge clk);
      wen = 1'b0;
      rd_check(20'd50, 16'hBEEF, "pre-rst 50");

      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("rst clears err0", 32'(err0), 32'd0);
      check("rst clears err1", 32'(err1), 32'd0);
      repeat (150) @(negedge clk);
      check("mid-sweep busy0", 32'(busy0), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      wen = 1'b1; waddr = 20'd100; wdata = 16'h5555;
      ren = 1'b1; raddr = 20'd500;
      sweep(n0, n1, pv);
      wen = 1'b0; ren = 1'b0;
      check("resweep len0", 32'(n0), 32'd400);
      check("resweep len1", 32'(n1), 32'd400);
      check("sweep no rvalid", 32'(pv), 32'd0);
      check("sweep no err0", 32'(err0), 32'd0);
      check("sweep no err1", 32'(err1), 32'd0);
      rd_check(20'd50,  16'h0000, "post 50");
      rd_check(20'd100, 16'h0000, "post 100");
      rd_check(20'd0,   16'h0000, "post 0");
      rd_check(20'd399, 16'h0000, "post 399");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
